// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI3 instruction/data bus arbiter.
package axi_arb_pkg;

    localparam int ARB_ID_W_DEF = 4;

    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

    // The held AR id is sized by ARB_ID_W_DEF, which must match the top's ARB_ID_W.
    typedef struct packed {
        logic [ARB_ID_W_DEF-1:0] id;
        logic [31:0]             addr;
        logic [3:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic [1:0]              lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
    } ar_req_t;

endpackage

// File: rtl/axi_rr_picker.sv
// Two-way read grant picker; ARB_ROUND_ROBIN_EN selects round-robin, otherwise data beats instruction.
module axi_rr_picker
    import axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    // Choose the winner; with no request the pick is don't-care and follows last_grant.
    always_comb begin
        grant = GRANT_INST;
`ifdef ARB_ROUND_ROBIN_EN
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = GRANT_DATA;
        end else if (req[0]) begin
            grant = GRANT_INST;
        end else begin
            grant = last_grant;
        end
`else
        if (req[1]) begin
            grant = GRANT_DATA;
        end else if (req[0]) begin
            grant = GRANT_INST;
        end else begin
            grant = last_grant;
        end
`endif
    end

endmodule

// File: rtl/axi_bus_arbiter.sv
// Shares one AXI3 master port between the I-cache reader (S0) and the data master (S1).
// Define ARB_ROUND_ROBIN_EN for round-robin read arbitration; default is fixed data-first priority.
module axi_bus_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ARB_ID_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ARB_ID_W-1:0] s0_arid,
    input  logic [31:0]         s0_araddr,
    input  logic [3:0]          s0_arlen,
    input  logic [2:0]          s0_arsize,
    input  logic [1:0]          s0_arburst,
    input  logic [1:0]          s0_arlock,
    input  logic [3:0]          s0_arcache,
    input  logic [2:0]          s0_arprot,
    input  logic                s0_arvalid,
    output logic                s0_arready,
    output logic [ARB_ID_W-1:0] s0_rid,
    output logic [31:0]         s0_rdata,
    output logic [1:0]          s0_rresp,
    output logic                s0_rlast,
    output logic                s0_rvalid,
    input  logic                s0_rready,
    input  logic [ARB_ID_W-1:0] s1_arid,
    input  logic [31:0]         s1_araddr,
    input  logic [3:0]          s1_arlen,
    input  logic [2:0]          s1_arsize,
    input  logic [1:0]          s1_arburst,
    input  logic [1:0]          s1_arlock,
    input  logic [3:0]          s1_arcache,
    input  logic [2:0]          s1_arprot,
    input  logic                s1_arvalid,
    output logic                s1_arready,
    output logic [ARB_ID_W-1:0] s1_rid,
    output logic [31:0]         s1_rdata,
    output logic [1:0]          s1_rresp,
    output logic                s1_rlast,
    output logic                s1_rvalid,
    input  logic                s1_rready,
    input  logic [ARB_ID_W-1:0] s1_awid,
    input  logic [31:0]         s1_awaddr,
    input  logic [3:0]          s1_awlen,
    input  logic [2:0]          s1_awsize,
    input  logic [1:0]          s1_awburst,
    input  logic [1:0]          s1_awlock,
    input  logic [3:0]          s1_awcache,
    input  logic [2:0]          s1_awprot,
    input  logic                s1_awvalid,
    output logic                s1_awready,
    input  logic [ARB_ID_W-1:0] s1_wid,
    input  logic [31:0]         s1_wdata,
    input  logic [3:0]          s1_wstrb,
    input  logic                s1_wlast,
    input  logic                s1_wvalid,
    output logic                s1_wready,
    output logic [ARB_ID_W-1:0] s1_bid,
    output logic [1:0]          s1_bresp,
    output logic                s1_bvalid,
    input  logic                s1_bready,
    output logic [ARB_ID_W-1:0] m_arid,
    output logic [31:0]         m_araddr,
    output logic [3:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic [1:0]          m_arlock,
    output logic [3:0]          m_arcache,
    output logic [2:0]          m_arprot,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [ARB_ID_W-1:0] m_rid,
    input  logic [31:0]         m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic                m_rvalid,
    output logic                m_rready,
    output logic [ARB_ID_W-1:0] m_awid,
    output logic [31:0]         m_awaddr,
    output logic [3:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic [1:0]          m_awlock,
    output logic [3:0]          m_awcache,
    output logic [2:0]          m_awprot,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ARB_ID_W-1:0] m_wid,
    output logic [31:0]         m_wdata,
    output logic [3:0]          m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [ARB_ID_W-1:0] m_bid,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready
);

    r_state_t state_r, state_nxt_s;
    ar_req_t  ar_hold_r, ar_in_s;
    logic       grant_r, pick_s, last_grant_s, take_s, rd_data_s, r_done_s;
    logic       wr_busy_r, aw_hs_s, b_hs_s;
    logic [1:0] rd_req_s;

    // A pending S1 AW also holds off S1 reads so the write is always ordered first.
    assign rd_req_s  = {s1_arvalid && !wr_busy_r && !s1_awvalid, s0_arvalid};
    assign take_s    = (state_r == R_IDLE) && (|rd_req_s);
    assign rd_data_s = (state_r == R_DATA);
    assign r_done_s  = rd_data_s && m_rvalid && m_rready && m_rlast;

    axi_rr_picker u_picker (
        .req        (rd_req_s),
        .last_grant (last_grant_s),
        .grant      (pick_s)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_r;

    // Remember who was served last; a blocked S1 never reaches the picker, so keeps its turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= GRANT_DATA;
        end else if (take_s) begin
            last_grant_r <= pick_s;
        end
    end

    assign last_grant_s = last_grant_r;
`else
    assign last_grant_s = GRANT_DATA;
`endif

    // Select the AR fields of the master about to be granted.
    always_comb begin
        ar_in_s = '0;
        if (pick_s == GRANT_DATA) begin
            ar_in_s.id    = ARB_ID_W_DEF'(s1_arid);
            ar_in_s.addr  = s1_araddr;
            ar_in_s.len   = s1_arlen;
            ar_in_s.size  = s1_arsize;
            ar_in_s.burst = s1_arburst;
            ar_in_s.lock  = s1_arlock;
            ar_in_s.cache = s1_arcache;
            ar_in_s.prot  = s1_arprot;
        end else begin
            ar_in_s.id    = ARB_ID_W_DEF'(s0_arid);
            ar_in_s.addr  = s0_araddr;
            ar_in_s.len   = s0_arlen;
            ar_in_s.size  = s0_arsize;
            ar_in_s.burst = s0_arburst;
            ar_in_s.lock  = s0_arlock;
            ar_in_s.cache = s0_arcache;
            ar_in_s.prot  = s0_arprot;
        end
    end

    // Read FSM next-state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            R_IDLE: begin
                if (take_s) state_nxt_s = R_ADDR;
                else        state_nxt_s = R_IDLE;
            end
            R_ADDR: begin
                if (m_arready) state_nxt_s = R_DATA;
                else           state_nxt_s = R_ADDR;
            end
            R_DATA: begin
                if (r_done_s) state_nxt_s = R_IDLE;
                else          state_nxt_s = R_DATA;
            end
            default: state_nxt_s = R_IDLE;
        endcase
    end

    // Read FSM state, grant and held AR request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= R_IDLE;
            grant_r   <= GRANT_INST;
            ar_hold_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (take_s) begin
                grant_r   <= pick_s;
                ar_hold_r <= ar_in_s;
            end
        end
    end

    assign aw_hs_s = s1_awvalid && !wr_busy_r && m_awready;
    assign b_hs_s  = m_bvalid && s1_bready;

    // Single outstanding write tracker; the B clear wins over a new AW.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_busy_r <= 1'b0;
        end else if (b_hs_s) begin
            wr_busy_r <= 1'b0;
        end else if (aw_hs_s) begin
            wr_busy_r <= 1'b1;
        end
    end

    assign s0_arready = take_s && (pick_s == GRANT_INST);
    assign s1_arready = take_s && (pick_s == GRANT_DATA);

    // ID bit 0 carries the grant downstream and is restored on the way back.
    assign m_arid    = {ar_hold_r.id[ARB_ID_W-1:1], grant_r};
    assign m_araddr  = ar_hold_r.addr;
    assign m_arlen   = ar_hold_r.len;
    assign m_arsize  = ar_hold_r.size;
    assign m_arburst = ar_hold_r.burst;
    assign m_arlock  = ar_hold_r.lock;
    assign m_arcache = ar_hold_r.cache;
    assign m_arprot  = ar_hold_r.prot;
    assign m_arvalid = (state_r == R_ADDR);

    assign s0_rid    = {m_rid[ARB_ID_W-1:1], ar_hold_r.id[0]};
    assign s0_rdata  = m_rdata;
    assign s0_rresp  = m_rresp;
    assign s0_rlast  = m_rlast;
    assign s0_rvalid = rd_data_s && (grant_r == GRANT_INST) && m_rvalid;
    assign s1_rid    = {m_rid[ARB_ID_W-1:1], ar_hold_r.id[0]};
    assign s1_rdata  = m_rdata;
    assign s1_rresp  = m_rresp;
    assign s1_rlast  = m_rlast;
    assign s1_rvalid = rd_data_s && (grant_r == GRANT_DATA) && m_rvalid;
    assign m_rready  = rd_data_s && ((grant_r == GRANT_DATA) ? s1_rready : s0_rready);

    assign m_awid     = s1_awid;
    assign m_awaddr   = s1_awaddr;
    assign m_awlen    = s1_awlen;
    assign m_awsize   = s1_awsize;
    assign m_awburst  = s1_awburst;
    assign m_awlock   = s1_awlock;
    assign m_awcache  = s1_awcache;
    assign m_awprot   = s1_awprot;
    assign m_awvalid  = s1_awvalid && !wr_busy_r;
    assign s1_awready = m_awready && !wr_busy_r;

    assign m_wid     = s1_wid;
    assign m_wdata   = s1_wdata;
    assign m_wstrb   = s1_wstrb;
    assign m_wlast   = s1_wlast;
    assign m_wvalid  = s1_wvalid;
    assign s1_wready = m_wready;

    assign s1_bid    = m_bid;
    assign s1_bresp  = m_bresp;
    assign s1_bvalid = m_bvalid;
    assign m_bready  = s1_bready;

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// Directed, self-checking bench for axi_bus_arbiter: write-path vector table plus read-burst sequences.
module tb_axi_bus_arbiter;
    import axi_arb_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic [3:0]  s0_arid, s1_arid, s0_rid, s1_rid, s1_awid, s1_wid, s1_bid;
    logic [31:0] s0_araddr, s1_araddr, s0_rdata, s1_rdata, s1_awaddr, s1_wdata;
    logic [3:0]  s0_arlen, s1_arlen, s0_arcache, s1_arcache, s1_awlen, s1_awcache, s1_wstrb;
    logic [2:0]  s0_arsize, s1_arsize, s0_arprot, s1_arprot, s1_awsize, s1_awprot;
    logic [1:0]  s0_arburst, s1_arburst, s0_arlock, s1_arlock, s1_awburst, s1_awlock;
    logic [1:0]  s0_rresp, s1_rresp, s1_bresp;
    logic s0_arvalid, s0_arready, s0_rlast, s0_rvalid, s0_rready;
    logic s1_arvalid, s1_arready, s1_rlast, s1_rvalid, s1_rready;
    logic s1_awvalid, s1_awready, s1_wlast, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
    logic [3:0]  m_arid, m_rid, m_awid, m_wid, m_bid, m_arlen, m_arcache, m_awlen, m_awcache, m_wstrb;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic [2:0]  m_arsize, m_arprot, m_awsize, m_awprot;
    logic [1:0]  m_arburst, m_arlock, m_awburst, m_awlock, m_rresp, m_bresp;
    logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

    int tests = 0;
    int fails = 0;

    axi_bus_arbiter #(.ARB_ID_W(4)) dut (
        .clk(clk), .rst(rst),
        .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
        .s0_arburst(s0_arburst), .s0_arlock(s0_arlock), .s0_arcache(s0_arcache), .s0_arprot(s0_arprot),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_rid(s0_rid), .s0_rdata(s0_rdata),
        .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
        .s1_arburst(s1_arburst), .s1_arlock(s1_arlock), .s1_arcache(s1_arcache), .s1_arprot(s1_arprot),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_rid(s1_rid), .s1_rdata(s1_rdata),
        .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .s1_awid(s1_awid), .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awsize(s1_awsize),
        .s1_awburst(s1_awburst), .s1_awlock(s1_awlock), .s1_awcache(s1_awcache), .s1_awprot(s1_awprot),
        .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_wid(s1_wid), .s1_wdata(s1_wdata),
        .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
        .s1_bid(s1_bid), .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wid(m_wid), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 clk = ~clk;

    // Write-path vector: inputs, then {m_awvalid, s1_awready, m_wvalid, s1_wready, s1_bvalid, m_bready, wr_busy}.
    typedef struct packed {
        logic awv, awr, wv, wr, bv, br;
        logic [6:0] exp;
    } wvec_t;
    wvec_t wtab [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        {s0_arid, s0_araddr, s0_arlen, s0_arlock, s0_arcache, s0_arprot, s0_arvalid, s0_rready} = '0;
        {s1_arid, s1_araddr, s1_arlen, s1_arlock, s1_arcache, s1_arprot, s1_arvalid, s1_rready} = '0;
        s0_arsize = 3'd2; s0_arburst = 2'b01; s1_arsize = 3'd2; s1_arburst = 2'b01;
        {s1_awid, s1_awaddr, s1_awlen, s1_awsize, s1_awburst, s1_awlock, s1_awcache, s1_awprot, s1_awvalid} = '0;
        {s1_wid, s1_wdata, s1_wstrb, s1_wlast, s1_wvalid, s1_bready} = '0;
        {m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid} = '0;
        {m_awready, m_wready, m_bid, m_bresp, m_bvalid} = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Caller has the winner's AR valid and the arbiter idle; runs one burst through to R_IDLE.
    task automatic run_burst(input bit who, input logic [3:0] id, input logic [31:0] addr,
                             input int nbeats, input bit toggle);
        logic [31:0] dbase;
        int beat;
        int cyc;
        logic rr;
        dbase = addr ^ 32'hA5A5_0000;
        #1;
        check("arready_win", 64'(who ? s1_arready : s0_arready), 64'(1'b1));
        check("arready_lose", 64'(who ? s0_arready : s1_arready), 64'(1'b0));
        tick();
        if (who) s1_arvalid = 1'b0; else s0_arvalid = 1'b0;
        #1;
        check("m_arvalid", 64'(m_arvalid), 64'(1'b1));
        check("m_arid", 64'(m_arid), 64'({id[3:1], who}));
        check("m_araddr", 64'(m_araddr), 64'(addr));
        check("m_arlen", 64'(m_arlen), 64'(nbeats - 1));
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        beat = 0;
        cyc = 0;
        rr = 1'b1;
        while (beat < nbeats && cyc < 80) begin
            if (who) s1_rready = rr; else s0_rready = rr;
            m_rvalid = 1'b1;
            m_rdata  = dbase + 32'(beat);
            m_rlast  = (beat == nbeats - 1);
            m_rid    = {id[3:1], who};
            #1;
            check("m_rready_mirror", 64'(m_rready), 64'(rr));
            check("rvalid_win", 64'(who ? s1_rvalid : s0_rvalid), 64'(1'b1));
            check("rvalid_lose", 64'(who ? s0_rvalid : s1_rvalid), 64'(1'b0));
            if (rr) begin
                check("rdata", 64'(who ? s1_rdata : s0_rdata), 64'(dbase + 32'(beat)));
                check("rlast", 64'(who ? s1_rlast : s0_rlast), 64'(beat == nbeats - 1));
                check("rid", 64'(who ? s1_rid : s0_rid), 64'(id));
                beat++;
            end
            tick();
            cyc++;
            if (toggle) rr = ~rr;
        end
        check("burst_beats", 64'(beat), 64'(nbeats));
        m_rvalid = 1'b0; m_rlast = 1'b0; s0_rready = 1'b0; s1_rready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wtab[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0100000};
        wtab[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1000000};
        wtab[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1100000};
        wtab[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0011001};
        wtab[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0000101};
        wtab[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'b0000111};
        wtab[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1100000};
        wtab[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000001};
        wtab[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'b0000111};
        wtab[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check("rst_state", 64'(dut.state_r == R_IDLE), 64'(1'b1));
        check("rst_wr_busy", 64'(dut.wr_busy_r), 64'(1'b0));
        check("rst_grant", 64'(dut.grant_r), 64'(1'b0));
        check("rst_m_valids", 64'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}), 64'(5'b0));
        check("rst_s_outs", 64'({s0_arready, s1_arready, s0_rvalid, s1_rvalid, s1_bvalid}), 64'(5'b0));
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            s1_awvalid = wtab[i].awv; m_awready = wtab[i].awr;
            s1_wvalid  = wtab[i].wv;  m_wready  = wtab[i].wr;
            m_bvalid   = wtab[i].bv;  s1_bready = wtab[i].br;
            s1_awaddr  = 32'h1000_0000 + 32'(i);
            #1;
            check($sformatf("wr_row%0d", i),
                  64'({m_awvalid, s1_awready, m_wvalid, s1_wready, s1_bvalid, m_bready, dut.wr_busy_r}),
                  64'(wtab[i].exp));
            check($sformatf("wr_addr%0d", i), 64'(m_awaddr), 64'(32'h1000_0000 + 32'(i)));
            tick();
        end
        idle_inputs();
        tick();

        // Both request together; fixed priority serves S1 first, round-robin from reset serves S0 first.
        s0_arid = 4'h6; s0_araddr = 32'h0000_1000; s0_arlen = 4'd15; s0_arvalid = 1'b1;
        s1_arid = 4'h9; s1_araddr = 32'h0000_1000; s1_arlen = 4'd15; s1_arvalid = 1'b1;
        if (RR_EN) begin
            run_burst(1'b0, 4'h6, 32'h0000_1000, 16, 1'b0);
            run_burst(1'b1, 4'h9, 32'h0000_1000, 16, 1'b0);
        end else begin
            run_burst(1'b1, 4'h9, 32'h0000_1000, 16, 1'b0);
            run_burst(1'b0, 4'h6, 32'h0000_1000, 16, 1'b0);
        end

        // ID restore on both masters.
        s1_arid = 4'b0011; s1_araddr = 32'h0000_2000; s1_arlen = 4'd0; s1_arvalid = 1'b1;
        run_burst(1'b1, 4'b0011, 32'h0000_2000, 1, 1'b0);
        s0_arid = 4'b0011; s0_araddr = 32'h0000_2100; s0_arlen = 4'd0; s0_arvalid = 1'b1;
        run_burst(1'b0, 4'b0011, 32'h0000_2100, 1, 1'b0);

        // Backpressure: rready toggles every cycle over 8 beats.
        s0_arid = 4'h4; s0_araddr = 32'h0000_3000; s0_arlen = 4'd7; s0_arvalid = 1'b1;
        run_burst(1'b0, 4'h4, 32'h0000_3000, 8, 1'b1);

        // Write blocking: S1 AR with AW in the same cycle waits for B; S0 keeps going.
        s1_arid = 4'hB; s1_araddr = 32'h0000_4000; s1_arlen = 4'd1; s1_arvalid = 1'b1;
        s1_awid = 4'h1; s1_awaddr = 32'hBFAF_0000; s1_awvalid = 1'b1; m_awready = 1'b1;
        #1;
        check("wb_aw_fwd", 64'({m_awvalid, s1_awready}), 64'(2'b11));
        check("wb_m_awaddr", 64'(m_awaddr), 64'(32'hBFAF_0000));
        check("wb_ar_same_cycle", 64'(s1_arready), 64'(1'b0));
        tick();
        s1_awvalid = 1'b0; m_awready = 1'b0;
        s1_wvalid = 1'b1; s1_wlast = 1'b1; s1_wdata = 32'hCAFE_F00D; m_wready = 1'b1;
        #1;
        check("wb_busy", 64'(dut.wr_busy_r), 64'(1'b1));
        check("wb_w_pass", 64'({m_wvalid, s1_wready, m_wdata}), 64'({2'b11, 32'hCAFE_F00D}));
        check("wb_ar_blocked0", 64'(s1_arready), 64'(1'b0));
        tick();
        s1_wvalid = 1'b0; s1_wlast = 1'b0; m_wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("wb_ar_blocked1", 64'(s1_arready), 64'(1'b0));
            tick();
        end
        s0_arid = 4'h6; s0_araddr = 32'h0000_5000; s0_arlen = 4'd1; s0_arvalid = 1'b1;
        run_burst(1'b0, 4'h6, 32'h0000_5000, 2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("wb_ar_blocked2", 64'({s1_arready, m_arvalid}), 64'(2'b00));
            tick();
        end
        m_bvalid = 1'b1; m_bid = 4'h1; s1_bready = 1'b1;
        #1;
        check("wb_b_pass", 64'({s1_bvalid, m_bready, s1_bid}), 64'({2'b11, 4'h1}));
        check("wb_ar_at_b", 64'(s1_arready), 64'(1'b0));
        tick();
        m_bvalid = 1'b0; s1_bready = 1'b0;
        #1;
        check("wb_busy_clear", 64'(dut.wr_busy_r), 64'(1'b0));
        run_burst(1'b1, 4'hB, 32'h0000_4000, 2, 1'b0);

        // Reset at beat 5 of a 16-beat burst with a write outstanding.
        s1_awvalid = 1'b1; m_awready = 1'b1;
        tick();
        s1_awvalid = 1'b0; m_awready = 1'b0;
        s0_arid = 4'h2; s0_araddr = 32'h0000_6000; s0_arlen = 4'd15; s0_arvalid = 1'b1;
        tick();
        s0_arvalid = 1'b0; m_arready = 1'b1;
        tick();
        m_arready = 1'b0; s0_rready = 1'b1; m_rid = 4'h2;
        for (int b = 0; b < 5; b++) begin
            m_rvalid = 1'b1; m_rdata = 32'(b);
            tick();
        end
        m_rdata = 32'd5;
        #1;
        check("rstmid_pre", 64'({s0_rvalid, dut.wr_busy_r}), 64'(2'b11));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstmid_state", 64'(dut.state_r == R_IDLE), 64'(1'b1));
        check("rstmid_outs", 64'({m_arvalid, dut.wr_busy_r, s0_rvalid, s1_rvalid, m_rready}), 64'(5'b0));
        idle_inputs();
        do_reset();

        // Both request continuously for 4 bursts.
        s0_arid = 4'h6; s0_araddr = 32'h0000_7000; s0_arlen = 4'd1; s0_arvalid = 1'b1;
        s1_arid = 4'h9; s1_araddr = 32'h0000_7100; s1_arlen = 4'd1; s1_arvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bit who;
            who = RR_EN ? bit'(k % 2) : 1'b1;
            run_burst(who, who ? 4'h9 : 4'h6, who ? 32'h0000_7100 : 32'h0000_7000, 2, 1'b0);
            if (who) s1_arvalid = 1'b1; else s0_arvalid = 1'b1;
        end
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
